// File: rtl/ahb_master_req_gen_pkg.sv
// AHB master-side types: burst/transfer encodings, request FSM states and burst helpers.
// Pure declarations; no state, no latency.
package AHB_package;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  // State names are prefixed so they don't collide with the htrans encodings.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } req_state_e;

  // Returns beats-1 so it fits the 4-bit beat counter.
  function automatic logic [3:0] burst_beats(input hburst_type burst);
    case (burst)
      WRAP4, INCR4:   burst_beats = 4'd3;
      WRAP8, INCR8:   burst_beats = 4'd7;
      WRAP16, INCR16: burst_beats = 4'd15;
      default:        burst_beats = 4'd0;
    endcase
  endfunction

  function automatic logic is_wrap(input hburst_type burst);
    is_wrap = (burst == WRAP4) || (burst == WRAP8) || (burst == WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// Combinational next-beat address for an AHB burst (incrementing or wrapping).
// Zero latency; no flow control.
module ahb_burst_addr_gen
  import AHB_package::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  hburst_type        burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] boundary;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] incr;

  always_comb begin
    bytes       = ADDR_W'(1) << size_i;
    boundary    = ADDR_W'({1'b0, burst_beats(burst_i)} + 5'd1) << size_i;
    mask        = boundary - ADDR_W'(1);
    incr        = addr_i + bytes;
    // Wrapping keeps the upper bits of the burst window and wraps the offset.
    next_addr_o = is_wrap(burst_i) ? ((addr_i & ~mask) | (incr & mask)) : incr;
  end

endmodule

// File: rtl/ahb_master_req_gen.sv
// Per-master AHB request/burst initiator: latches a command, requests the bus, issues beats on grant.
// One beat per granted ACTIVE cycle; hwait/grant loss hold the beat; cmd_ready only in IDLE.
module ahb_master_req_gen
  import AHB_package::*;
#(
  parameter int ADDR_W      = 32,
  parameter int PRIOR_LEVEL = 2,
  parameter int PRIOR_BIT   = $clog2(PRIOR_LEVEL)
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  hburst_type           cmd_burst,
  input  logic [2:0]           cmd_size,
  input  logic                 cmd_write,
  input  logic [PRIOR_BIT-1:0] cmd_prior,
  output logic                 hreq,
  output logic [PRIOR_BIT-1:0] hprior,
  input  logic                 hgrant,
  input  logic                 hwait,
  output logic [ADDR_W-1:0]    haddr,
  output htrans_type           htrans,
  output hburst_type           hburst,
  output logic [2:0]           hsize,
  output logic                 hwrite,
  output logic                 done
);

  req_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  hburst_type           burst_q;
  logic [2:0]           size_q;
  logic                 write_q;
  logic [PRIOR_BIT-1:0] prior_q;
  logic [3:0]           cnt_q;
  logic                 lost_q;
  logic                 done_q;
  logic                 accept;
  logic                 last;
  logic                 active;
  logic [ADDR_W-1:0]    next_addr;

  ahb_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    hreq      = 1'b0;
    htrans    = IDLE;
    accept    = 1'b0;
    last      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        hreq = 1'b1;
        if (hgrant || hwait) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        hreq   = 1'b1;
        htrans = ((cnt_q == 4'd0) || lost_q) ? NONSEQ : SEQ;
        accept = hgrant;
        last   = (cnt_q == burst_beats(burst_q));
        if (accept && last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      burst_q <= SINGLE;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      prior_q <= '0;
      cnt_q   <= 4'd0;
      lost_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= accept && last;
      if ((state_q == ST_IDLE) && cmd_valid) begin
        addr_q  <= cmd_addr;
        burst_q <= cmd_burst;
        size_q  <= cmd_size;
        write_q <= cmd_write;
        prior_q <= cmd_prior;
        cnt_q   <= 4'd0;
        lost_q  <= 1'b0;
      end else if (accept) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 4'd1;
        lost_q <= 1'b0;
      end else if ((state_q == ST_ACTIVE) && !hwait) begin
        // Grant withdrawn without a wait: the held beat must restart as NONSEQ.
        lost_q <= 1'b1;
      end
    end
  end

  assign active = (state_q == ST_ACTIVE);
  assign hprior = (state_q != ST_IDLE) ? prior_q : '0;
  assign haddr  = active ? addr_q : '0;
  assign hburst = active ? burst_q : SINGLE;
  assign hsize  = active ? size_q : 3'd0;
  assign hwrite = active && write_q;
  assign done   = done_q;

endmodule

// File: tb/tb_ahb_master_req_gen.sv
// Self-checking bench for ahb_master_req_gen: directed burst scenarios plus randomized
// commands and grant/wait patterns checked against an arithmetic address/transfer model.
module tb_ahb_master_req_gen;
  import AHB_package::*;

  logic        hclk;
  logic        hreset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  hburst_type  cmd_burst;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic [0:0]  cmd_prior;
  logic        hreq;
  logic [0:0]  hprior;
  logic        hgrant;
  logic        hwait;
  logic [31:0] haddr;
  htrans_type  htrans;
  hburst_type  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        done;

  int checks = 0;
  int errors = 0;

  ahb_master_req_gen #(.ADDR_W(32), .PRIOR_LEVEL(2)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_write(cmd_write),
    .cmd_prior(cmd_prior), .hreq(hreq), .hprior(hprior), .hgrant(hgrant),
    .hwait(hwait), .haddr(haddr), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hwrite(hwrite), .done(done)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Reference model: beat count and the address of beat i from first principles.
  function automatic int m_beats(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4;
      WRAP8, INCR8:   return 8;
      WRAP16, INCR16: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input hburst_type b,
                                          input logic [2:0] s, input int i);
    longint unsigned bytes, bnd, base, off;
    bytes = longint'(1) << s;
    if (b == WRAP4 || b == WRAP8 || b == WRAP16) begin
      bnd  = longint'(m_beats(b)) * bytes;
      base = longint'(a) - (longint'(a) % bnd);
      off  = ((longint'(a) - base) + longint'(i) * bytes) % bnd;
      return 32'(base + off);
    end
    return 32'(longint'(a) + longint'(i) * bytes);
  endfunction

  // Results gathered by run_burst for the calling test to judge.
  logic [31:0] obs_addr[$];
  htrans_type  obs_trans[$];
  htrans_type  exp_trans[$];
  int n_done, hold_err, attr_err, prior_err, hreq_gap;
  bit done_after_last, hreq_at_done, ready_at_done, timed_out;

  task automatic run_burst(input logic [31:0] a, input hburst_type b, input logic [2:0] s,
                           input logic w, input logic p, input int stall_at, input int stall_len,
                           input int lose_at, input int lose_len, input bit rnd);
    int beats, cyc, post, st_cnt, lo_cnt, idx, r;
    bit lost, holding, chk_next;
    logic [31:0] h_addr;
    htrans_type h_tr;
    obs_addr.delete(); obs_trans.delete(); exp_trans.delete();
    n_done = 0; hold_err = 0; attr_err = 0; prior_err = 0; hreq_gap = 0;
    done_after_last = 0; hreq_at_done = 1; ready_at_done = 0;
    beats = m_beats(b);
    st_cnt = 0; lo_cnt = 0; lost = 0; holding = 0; chk_next = 0; post = -1; cyc = 0;
    h_addr = '0; h_tr = IDLE;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_burst = b; cmd_size = s; cmd_write = w; cmd_prior = p;
    while (!cmd_ready && cyc < 50) begin @(negedge hclk); cyc++; end
    @(negedge hclk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (cyc < 600) begin
      if (holding && (haddr !== h_addr || htrans !== h_tr)) hold_err++;
      holding = 0;
      if (done) n_done++;
      if (chk_next) begin
        chk_next = 0; post = 0;
        done_after_last = done; hreq_at_done = hreq; ready_at_done = cmd_ready;
      end
      if (post >= 0) begin
        if (post == 2) break;
        post++;
      end
      if (!hreq && post < 0) hreq_gap++;
      hgrant = 1'b0; hwait = 1'b0;
      if (hreq && hprior !== p) prior_err++;
      if (hreq && htrans == IDLE) begin
        hgrant = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end else if (hreq) begin
        idx = obs_addr.size();
        if (idx == stall_at && st_cnt < stall_len) begin
          hwait = 1'b1; st_cnt++;
        end else if (idx == lose_at && lo_cnt < lose_len) begin
          lo_cnt++;
        end else if (rnd) begin
          r = $urandom_range(0, 9);
          if (r < 6) hgrant = 1'b1;
          else if (r < 8) hwait = 1'b1;
        end else begin
          hgrant = 1'b1;
        end
        if (hwait) begin holding = 1; h_addr = haddr; h_tr = htrans; end
        if (hgrant) begin
          obs_addr.push_back(haddr);
          obs_trans.push_back(htrans);
          exp_trans.push_back((idx == 0 || lost) ? NONSEQ : SEQ);
          lost = 0;
          if (hsize !== s || hburst !== b || hwrite !== w) attr_err++;
          if (idx == beats - 1) chk_next = 1;
        end else if (!hwait) begin
          lost = 1;
        end
      end
      @(negedge hclk);
      cyc++;
    end
    timed_out = (post < 0);
    hgrant = 1'b0; hwait = 1'b0;
  endtask

  task automatic test_reset;
    hreset_n = 1'b0; cmd_valid = 1'b0; hgrant = 1'b0; hwait = 1'b0;
    cmd_addr = '0; cmd_burst = SINGLE; cmd_size = 3'd0; cmd_write = 1'b0; cmd_prior = 1'b0;
    repeat (3) @(negedge hclk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (hreq !== 1'b0) begin errors++; $display("FAIL reset_hreq got %b want 0", hreq); end
    checks++; if (htrans !== IDLE) begin errors++; $display("FAIL reset_htrans got %0d want 0", htrans); end
    checks++; if (hburst !== SINGLE) begin errors++; $display("FAIL reset_hburst got %0d want 0", hburst); end
    checks++; if ({haddr, hsize, hwrite, hprior, done} !== 38'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {haddr, hsize, hwrite, hprior, done});
    end
    hreset_n = 1'b1;
    @(negedge hclk);
    checks++; if (cmd_ready !== 1'b1 || hreq !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got ready=%b hreq=%b want 1/0", cmd_ready, hreq);
    end
  endtask

  task automatic test_incr4;
    logic [31:0] e[4];
    htrans_type  t[4];
    e = '{32'h100, 32'h104, 32'h108, 32'h10C};
    t = '{NONSEQ, SEQ, SEQ, SEQ};
    run_burst(32'h100, INCR4, 3'd2, 1'b1, 1'b1, -1, 0, -1, 0, 1'b0);
    checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL incr4_beats got %0d want 4", obs_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_addr[i] !== e[i]) begin errors++; $display("FAIL incr4_addr%0d got %h want %h", i, obs_addr[i], e[i]); end
      checks++; if (obs_trans[i] !== t[i]) begin errors++; $display("FAIL incr4_trans%0d got %0d want %0d", i, obs_trans[i], t[i]); end
    end
    checks++; if (n_done != 1 || done_after_last !== 1'b1) begin
      errors++; $display("FAIL incr4_done got count=%0d timing=%b want 1/1", n_done, done_after_last);
    end
    checks++; if (hreq_at_done !== 1'b0 || ready_at_done !== 1'b1) begin
      errors++; $display("FAIL incr4_release got hreq=%b ready=%b want 0/1", hreq_at_done, ready_at_done);
    end
    checks++; if (attr_err != 0 || prior_err != 0) begin
      errors++; $display("FAIL incr4_attr got attr=%0d prior=%0d want 0/0", attr_err, prior_err);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] e4[4];
    logic [31:0] e8[8];
    e4 = '{32'h38, 32'h3C, 32'h30, 32'h34};
    e8 = '{32'h1E, 32'h10, 32'h12, 32'h14, 32'h16, 32'h18, 32'h1A, 32'h1C};
    run_burst(32'h38, WRAP4, 3'd2, 1'b0, 1'b0, -1, 0, -1, 0, 1'b0);
    checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL wrap4_beats got %0d want 4", obs_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs_addr[i] !== e4[i]) begin errors++; $display("FAIL wrap4_addr%0d got %h want %h", i, obs_addr[i], e4[i]); end
    end
    run_burst(32'h1E, WRAP8, 3'd1, 1'b1, 1'b0, -1, 0, -1, 0, 1'b0);
    checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL wrap8_beats got %0d want 8", obs_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (obs_addr[i] !== e8[i]) begin errors++; $display("FAIL wrap8_addr%0d got %h want %h", i, obs_addr[i], e8[i]); end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL wrap8_done got %0d want 1", n_done); end
  endtask

  task automatic test_stall;
    run_burst(32'h200, INCR8, 3'd2, 1'b0, 1'b1, 2, 3, -1, 0, 1'b0);
    checks++; if (obs_addr.size() != 8) begin errors++; $display("FAIL stall_beats got %0d want 8", obs_addr.size()); end
    checks++; if (hold_err != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", hold_err); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL stall_done got %0d want 1", n_done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (obs_addr[i] !== m_addr(32'h200, INCR8, 3'd2, i) || obs_trans[i] !== exp_trans[i]) begin
        errors++; $display("FAIL stall_beat%0d got %h/%0d want %h/%0d", i, obs_addr[i], obs_trans[i],
                           m_addr(32'h200, INCR8, 3'd2, i), exp_trans[i]);
      end
    end
  endtask

  task automatic test_lost_grant;
    run_burst(32'h100, INCR4, 3'd2, 1'b1, 1'b0, -1, 0, 2, 2, 1'b0);
    checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL lost_beats got %0d want 4", obs_addr.size()); end
    checks++; if (hreq_gap != 0) begin errors++; $display("FAIL lost_hreq_drop got %0d low cycles want 0", hreq_gap); end
    checks++; if (obs_addr[2] !== 32'h108 || obs_trans[2] !== NONSEQ) begin
      errors++; $display("FAIL lost_reissue got %h/%0d want 108/%0d", obs_addr[2], obs_trans[2], NONSEQ);
    end
    checks++; if (obs_trans[1] !== SEQ || obs_trans[3] !== SEQ || obs_addr[3] !== 32'h10C) begin
      errors++; $display("FAIL lost_neighbours got %0d/%0d/%h want SEQ/SEQ/10c", obs_trans[1], obs_trans[3], obs_addr[3]);
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL lost_done got %0d want 1", n_done); end
  endtask

  task automatic test_back_to_back;
    int cyc, done_cyc, acc_cyc, n_acc, nd;
    bit ready_at_first, second_loaded;
    logic [31:0] acc_addr[2];
    htrans_type acc_tr[2];
    cyc = 0; done_cyc = -1; acc_cyc = -1; n_acc = 0; nd = 0; ready_at_first = 0; second_loaded = 0;
    acc_addr = '{32'h0, 32'h0}; acc_tr = '{IDLE, IDLE};
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = 32'h40; cmd_burst = SINGLE; cmd_size = 3'd2; cmd_write = 1'b1; cmd_prior = 1'b0;
    while (cyc < 60 && !(n_acc == 2 && nd == 2)) begin
      hgrant = hreq;
      if (!second_loaded && hreq) begin
        second_loaded = 1;
        cmd_addr = 32'h80; cmd_size = 3'd0; cmd_write = 1'b0; cmd_prior = 1'b1;
      end
      if (done) begin
        nd++;
        if (nd == 1) begin done_cyc = cyc; ready_at_first = cmd_ready; end
      end
      if (nd >= 1 && hreq && htrans == IDLE) cmd_valid = 1'b0;
      if (hreq && htrans != IDLE && hgrant) begin
        if (n_acc < 2) begin acc_addr[n_acc] = haddr; acc_tr[n_acc] = htrans; end
        if (n_acc == 1) acc_cyc = cyc;
        n_acc++;
      end
      @(negedge hclk);
      cyc++;
    end
    hgrant = 1'b0; cmd_valid = 1'b0;
    checks++; if (n_acc != 2 || nd != 2) begin errors++; $display("FAIL b2b_counts got acc=%0d done=%0d want 2/2", n_acc, nd); end
    checks++; if (ready_at_first !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b want 1", ready_at_first); end
    checks++; if (acc_addr[0] !== 32'h40 || acc_addr[1] !== 32'h80) begin
      errors++; $display("FAIL b2b_addr got %h/%h want 40/80", acc_addr[0], acc_addr[1]);
    end
    checks++; if (acc_tr[0] !== NONSEQ || acc_tr[1] !== NONSEQ) begin
      errors++; $display("FAIL b2b_trans got %0d/%0d want NONSEQ/NONSEQ", acc_tr[0], acc_tr[1]);
    end
    checks++; if (acc_cyc - done_cyc != 2) begin
      errors++; $display("FAIL b2b_gap got %0d cycles want 2", acc_cyc - done_cyc);
    end
  endtask

  task automatic test_reset_mid_burst;
    int cyc, n_acc, nd;
    bit hit;
    cyc = 0; n_acc = 0; nd = 0; hit = 0;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_burst = INCR16; cmd_size = 3'd2; cmd_write = 1'b1; cmd_prior = 1'b1;
    while (cyc < 100 && !hit) begin
      if (!cmd_ready) cmd_valid = 1'b0;
      if (hreq && htrans != IDLE && n_acc == 5) begin
        hreset_n = 1'b0;
        #1;
        hit = 1;
        checks++; if (hreq !== 1'b0) begin errors++; $display("FAIL rst_mid_hreq got %b want 0", hreq); end
        checks++; if (htrans !== IDLE) begin errors++; $display("FAIL rst_mid_htrans got %0d want 0", htrans); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", cmd_ready); end
      end else begin
        hgrant = hreq;
        if (hreq && htrans != IDLE) n_acc++;
        @(negedge hclk);
        cyc++;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach got beats=%0d want 5", n_acc); end
    hgrant = 1'b0; cmd_valid = 1'b0;
    @(negedge hclk);
    hreset_n = 1'b1;
    repeat (20) begin @(negedge hclk); if (done) nd++; end
    checks++; if (nd != 0 || hreq !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after got done=%0d hreq=%b want 0/0", nd, hreq);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    hburst_type b;
    logic [2:0] s;
    logic w, p;
    int bad_addr, bad_tr, nb;
    for (int k = 0; k < 25; k++) begin
      s = 3'($urandom_range(0, 2));
      b = hburst_type'(3'($urandom_range(0, 7)));
      a = $urandom & ~((32'd1 << s) - 32'd1);
      w = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      nb = m_beats(b);
      run_burst(a, b, s, w, p, -1, 0, -1, 0, 1'b1);
      bad_addr = 0; bad_tr = 0;
      for (int i = 0; i < obs_addr.size(); i++) begin
        if (obs_addr[i] !== m_addr(a, b, s, i)) bad_addr++;
        if (obs_trans[i] !== exp_trans[i]) bad_tr++;
      end
      checks++; if (timed_out || obs_addr.size() != nb) begin
        errors++; $display("FAIL rnd%0d_beats got %0d timeout=%b want %0d", k, obs_addr.size(), timed_out, nb);
      end
      checks++; if (bad_addr != 0) begin errors++; $display("FAIL rnd%0d_addr got %0d bad beats want 0 (burst %0d a=%h)", k, bad_addr, b, a); end
      checks++; if (bad_tr != 0) begin errors++; $display("FAIL rnd%0d_trans got %0d bad beats want 0", k, bad_tr); end
      checks++; if (n_done != 1 || done_after_last !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_done got count=%0d timing=%b want 1/1", k, n_done, done_after_last);
      end
      checks++; if (hold_err != 0 || attr_err != 0 || prior_err != 0) begin
        errors++; $display("FAIL rnd%0d_hold_attr got %0d/%0d/%0d want 0/0/0", k, hold_err, attr_err, prior_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr4();
    test_wrap();
    test_stall();
    test_lost_grant();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
